arbitro_rr_moore: RTL
=====================

Name: arbitro_rr_moore

Overview:
- Moore-style round-robin arbiter that shares one resource among N requesters, e.g. a single Moore datapath or a bus port.
- Each requester uses a four-phase handshake: raise req_i, receive gnt_i, use the resource, drop req_i, see gnt_i drop.
- All outputs decode from the state register STAR and a last-served pointer only. Grants therefore appear one clock after the request is sampled.

Parameters:
- N, 4, number of requesters; N >= 2.
- W, $clog2(N), width of the owner index and last-served pointer.
- HOLD_MAX, 15, maximum grant length in clocks. Used only when the optional feature is compiled in.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_  input  1  synchronous active-low reset, sampled on posedge clock.
- req  input  N  request lines, one per requester, level-held.
- gnt  output  N  one-hot grant; all zero when nobody owns the resource.
- busy  output  1  high while a grant is active.
- owner  output  W  index of the current or most recent grantee.
- timeout  output  1  high while a grant is being forcibly revoked (TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset: posedge clock with reset_==0 sets STAR=IDLE and LAST=N-1. Outputs after that edge: gnt=0, busy=0, owner=N-1, timeout=0. Requester 0 has top priority after reset. Reset dominates all other conditions.
- Reset mid-grant: gnt drops at the reset edge. No handshake is completed.
- Output law (Moore, from STAR and LAST only):
  - IDLE: gnt=0, busy=0.
  - GRANT: gnt=1<<LAST, busy=1.
  - REVOKE: gnt=0, busy=0, timeout=1.
  - owner=LAST in every state.
- IDLE:
  - If any req bit is 1, pick the first index with req=1 scanning LAST+1, LAST+2, ... modulo N.
  - Set LAST to that index and go to GRANT.
  - With no requests, stay in IDLE.
  - Latency: request sampled at edge k, gnt visible after edge k.
- GRANT:
  - Stay while req[LAST]==1.
  - When req[LAST]==0 is sampled, go to IDLE; gnt drops after that edge.
  - There is always at least one IDLE cycle with gnt=0 between two owners. The same requester cannot chain grants without that gap.
- Non-owner requests during GRANT are not latched. They are only seen by the next IDLE scan, so a requester that drops req before being served is simply skipped.
- Fairness: an active requester is granted within N-1 other grants.
- Wrap-around: the scan index and LAST increment modulo N. With N=4 and LAST=3, the scan order is 0,1,2,3.
- Invariant: gnt is zero or exactly one-hot.

Optional Feature:
- Macro: ARBITRO_TIMEOUT_EN.
- Defined:
  - A hold counter (width $clog2(HOLD_MAX+1)) clears on entry to GRANT and increments each GRANT cycle.
  - If the counter reaches HOLD_MAX while req[LAST]==1, go to REVOKE.
  - REVOKE stays until req[LAST]==0 is sampled, then goes to IDLE. LAST stays put, so the rotation still advances past the offender.
  - If the counter reaches HOLD_MAX in the same cycle req[LAST] drops, the release wins: go to IDLE, and timeout stays 0.
- Not defined: no counter, no REVOKE state, timeout driven 0, grants are unbounded.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, GRANT=2'b01, REVOKE=2'b10;
  - the reset value of LAST (N-1);
  - the default HOLD_MAX.
- One natural sub-module, rr_picker: combinational, inputs req[N-1:0] and last[W-1:0], outputs found and idx[W-1:0]. This is the RCA portion of the next-state logic.
- STAR, LAST, the optional counter and the output decode stay in arbitro_rr_moore.

Test Plan:
- Reset then req=4'b0000 for 5 clocks -> gnt=0, busy=0, owner=3 throughout.
- From reset, req=4'b1111 held, each owner drops its req 3 cycles after its grant -> grants in order 0,1,2,3,0 with exactly one gnt=0 cycle between them.
- LAST=1, req=4'b0101 -> gnt=4'b0100 (index 2 before 0). After release, req=4'b0001 -> gnt=4'b0001 (wrap-around).
- Owner 2 holds; req[0] pulses high for 2 cycles mid-grant then drops -> requester 0 never granted; after release, state returns to IDLE with gnt=0.
- reset_=0 asserted while gnt=4'b0010 -> after that edge gnt=0, owner=3; with req=4'b0010 still high, first post-reset grant is 4'b0010.
- ARBITRO_TIMEOUT_EN, HOLD_MAX=15: requester 1 holds req → gnt drops and timeout=1 after 15 grant cycles; timeout clears after req[1] drops. With req=4'b1010, the next grant is 4'b1000.

Source files
------------

// File: rtl/arbitro_rr_moore_pkg.sv
// Shared definitions for the arbitro_rr_moore round-robin arbiter:
// state encodings, default sizing and the reset value of the last-served pointer.
package arbitro_rr_moore_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT  = 2'b01,
        REVOKE = 2'b10
    } state_e;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_HOLD_MAX = 15;

    // The pointer resets to the highest index so requester 0 is scanned first.
    function automatic int lastResetValue(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/arbitro_rr_moore_rr_picker.sv
// rr_picker: combinational round-robin search. Scans last+1, last+2, ...
// modulo N and returns the first requesting index.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] reqDbl;
    logic [W:0]     shamt;
    logic [N-1:0]   rot;
    logic [W:0]     sum;

    // Rotate the request vector so bit 0 corresponds to index last+1.
    always_comb begin
        reqDbl = {req, req};
        shamt  = {1'b0, last} + (W+1)'(1);
        rot    = reqDbl[shamt +: N];
    end

    // Lowest set bit of the rotated vector wins; map it back to an absolute index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, last} + (W+1)'(1) + (W+1)'(j);
                if (sum >= (W+1)'(N)) begin
                    sum = sum - (W+1)'(N);
                end
                idx = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_moore.sv
// arbitro_rr_moore: Moore round-robin arbiter with four-phase handshake.
// Outputs decode only from the state register and the last-served pointer.
// Optional grant-length limit enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_rr_moore
    import arbitro_rr_moore_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = $clog2(N)
`ifdef ARBITRO_TIMEOUT_EN
    ,
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX
`endif
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic [W-1:0] owner,
    output logic         timeout
);

    localparam logic [W-1:0] LAST_RST = W'(lastResetValue(N));

    state_e       state_q, state_d;
    logic [W-1:0] last_q, last_d;
    logic         pickFound;
    logic [W-1:0] pickIdx;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold_q, hold_d;
`endif

    rr_picker #(
        .N (N),
        .W (W)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .found (pickFound),
        .idx   (pickIdx)
    );

    // Next-state logic: scan in IDLE, hold while the owner keeps its request.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef ARBITRO_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d = GRANT;
                    last_d  = pickIdx;
`ifdef ARBITRO_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARBITRO_TIMEOUT_EN
                hold_d = hold_q + CW'(1);
`endif
                if (!req[last_q]) begin
                    state_d = IDLE;
                end
`ifdef ARBITRO_TIMEOUT_EN
                else if (hold_q == CW'(HOLD_MAX - 1)) begin
                    state_d = REVOKE;
                end
`endif
            end
`ifdef ARBITRO_TIMEOUT_EN
            REVOKE: begin
                if (!req[last_q]) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and hold counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
`ifdef ARBITRO_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef ARBITRO_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Moore output decode from state and pointer only.
    always_comb begin
        gnt     = '0;
        busy    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            GRANT: begin
                gnt[last_q] = 1'b1;
                busy        = 1'b1;
            end
`ifdef ARBITRO_TIMEOUT_EN
            REVOKE: begin
                timeout = 1'b1;
            end
`endif
            default: begin
                gnt = '0;
            end
        endcase
    end

    assign owner = last_q;

endmodule
